hazard_fwd_unit: RTL and testbench
==================================

# hazard_fwd_unit

Parametrised hazard and forwarding unit for the 5-stage pipelined ARM CPU, sitting alongside the ID/EX pipeline register. Unlike a purely combinational EX-stage comparator, it keeps its own shadow pipeline of in-flight destination registers. From that it produces registered forwarding selects for every source operand of the instruction entering EX, detects load-use hazards, and inserts bubbles. Depth of the forwarding window and operand count are parameters.

## Interface
- NUM_SRC, 2, number of source operands per instruction (Rn, Rm, ...)
- FWD_STAGES, 2, forwarding sources beyond EX (1 = EX/MEM, 2 = MEM/WB, ...); ≥1
- REG_W, 5, register index width
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high
- instValid_ID  input  1  ID holds a real instruction
- flush_ID  input  1  kill the ID instruction (taken branch)
- fwdEn_ID  input  NUM_SRC  per-operand forwarding enable (0 = operand unused)
- srcReg_ID  input  NUM_SRC×REG_W  source register indices
- RegWrite_ID, MemRead_ID  input  1 each  ID instruction writes a register / is a load
- targetReg_ID  input  REG_W  ID destination register
- stall_ID  output  1  combinational; hold PC and IF/ID, bubble into EX
- FWD_EX  output  NUM_SRC×SEL_W  registered mux selects for EX; SEL_W = clog2(FWD_STAGES+1)
- stallCount  output  16  only with HAZARD_STATS_EN

## Operation
- Shadow pipe: entries e[0..FWD_STAGES-1]; each holds {valid, regWrite, isLoad, rd}. e[0] = instruction now in EX, e[1] = MEM, and so on.
- Each cycle e[i] <= e[i-1] for i≥1. e[0] <= ID instruction if instValid_ID & !flush_ID & !stall_ID, else a bubble (valid=0).
- An entry "produces" reg r when valid & regWrite & rd==r & rd!=31. X31 is never forwarded.
- Select for operand k: if fwdEn_ID[k]=0 → 0. Otherwise the lowest j whose e[j] produces srcReg_ID[k] → code j+1 (1 = EX/MEM, 2 = MEM/WB). No match → 0 (register file). The nearest producer always wins.
- FWD_EX[k] <= computed select when the ID instruction advances. It is all-zero when a bubble is inserted (stall, flush, invalid).
- Load-use: stall_ID = instValid_ID & !flush_ID & e[0].isLoad & e[0] produces any enabled srcReg_ID[k].
- A stall lasts exactly one cycle. Next cycle the load is in e[1], the held instruction re-evaluates, and it gets code 2.
- Flush overrides stall. stall_ID=0, bubble into e[0].

## Timing
- Reset: all entries invalid, FWD_EX=0, stall_ID=0, stallCount=0. Reset mid-stall drops the stall the same edge.
- Select latency: decided in ID at cycle t, visible on FWD_EX at t+1 (aligned with the instruction in EX).
- stall_ID has zero-cycle latency from ID inputs and e[0].
- Back-to-back loads feeding each other: one stall each, never two consecutive stalls for one consumer.
- Same register written by e[0] and e[1]: code 1. Both operands hitting the same producer: both get the same code.

## Configuration
- HAZARD_STATS_EN defined: stallCount port exists. It increments on each cycle with stall_ID=1, saturates at 16'hFFFF, and is cleared by reset.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

## Structure
- hazard_pkg holds: typedef pipe_entry_t {valid, regWrite, isLoad, rd}, localparam ZERO_REG=5'd31, and a function fwd_sel_w(FWD_STAGES).
- Sub-module fwd_match: per-operand priority matcher (entries + srcReg + enable → select), instantiated NUM_SRC times via generate.

## Test plan
- ADD X1 in EX (e[0]), consumer with Rn=X1, Rm=X3 → next cycle FWD_EX = {A=1, B=0}, stall_ID=0.
- Producer X5 in e[1] only, consumer Rm=X5 with fwdEn=2'b11 → B=2. Same with fwdEn=2'b01 (Rm unused) → B=0.
- e[0] and e[1] both write X7, consumer Rn=X7 → A=1 (nearest wins).
- LDUR X2 in e[0], consumer Rn=X2 → stall_ID=1 one cycle, FWD_EX=0 (bubble). Next cycle stall_ID=0, then A=2. stallCount=1 with HAZARD_STATS_EN.
- Producer rd=X31 with RegWrite=1, consumer Rn=X31 → A=0. Load rd=X31 → no stall.
- Load-use hazard with flush_ID=1 → stall_ID=0, bubble. Reset asserted during a stall → FWD_EX=0, entries cleared next edge.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and helpers for the hazard/forwarding unit
package hazard_pkg;
    localparam int RD_W = 5;
    localparam logic [RD_W-1:0] ZERO_REG = 5'd31;

    typedef struct packed {
        logic            valid;
        logic            regWrite;
        logic            isLoad;
        logic [RD_W-1:0] rd;
    } pipe_entry_t;

    function automatic int fwd_sel_w(input int stages);
        return $clog2(stages + 1);
    endfunction
endpackage

// File: rtl/fwd_match.sv
// fwd_match: nearest-producer priority matcher for one source operand
module fwd_match import hazard_pkg::*; #(
    parameter int FWD_STAGES = 2,
    parameter int REG_W      = 5,
    parameter int SEL_W      = 2
) (
    input  pipe_entry_t [FWD_STAGES-1:0] e,
    input  logic [REG_W-1:0]             src,
    input  logic                         en,
    output logic [SEL_W-1:0]             sel,
    output logic                         ld
);
    // scan oldest to newest so the nearest producer is the last to assign
    always_comb begin
        sel = '0;
        ld  = 1'b0;
        for (int j = FWD_STAGES - 1; j >= 0; j--)
            if (en && e[j].valid && e[j].regWrite && e[j].rd != ZERO_REG && REG_W'(e[j].rd) == src) begin
                sel = SEL_W'(j + 1);
                ld  = e[j].isLoad;
            end
    end
endmodule

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: shadow-pipe forwarding selects and load-use stall generation
// HAZARD_STATS_EN adds a saturating stallCount output
module hazard_fwd_unit import hazard_pkg::*; #(
    parameter int NUM_SRC    = 2,
    parameter int FWD_STAGES = 2,
    parameter int REG_W      = 5,
    localparam int SEL_W     = fwd_sel_w(FWD_STAGES)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     instValid_ID,
    input  logic                     flush_ID,
    input  logic [NUM_SRC-1:0]       fwdEn_ID,
    input  logic [NUM_SRC*REG_W-1:0] srcReg_ID,
    input  logic                     RegWrite_ID,
    input  logic                     MemRead_ID,
    input  logic [REG_W-1:0]         targetReg_ID,
    output logic                     stall_ID,
    output logic [NUM_SRC*SEL_W-1:0] FWD_EX
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0]              stallCount
`endif
);
    pipe_entry_t [FWD_STAGES-1:0] e;
    pipe_entry_t                  nxt;
    logic [NUM_SRC*SEL_W-1:0]     sel;
    logic [NUM_SRC-1:0]           ld;
    logic [NUM_SRC-1:0]           load_hit;
    logic                         advance;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        fwd_match #(.FWD_STAGES(FWD_STAGES), .REG_W(REG_W), .SEL_W(SEL_W)) u_match (
            .e   (e),
            .src (srcReg_ID[k*REG_W +: REG_W]),
            .en  (fwdEn_ID[k]),
            .sel (sel[k*SEL_W +: SEL_W]),
            .ld  (ld[k])
        );
        assign load_hit[k] = ld[k] && sel[k*SEL_W +: SEL_W] == SEL_W'(1);
    end

    assign stall_ID = !reset && instValid_ID && !flush_ID && |load_hit;
    assign advance  = instValid_ID && !flush_ID && !stall_ID;
    assign nxt      = advance ? pipe_entry_t'{valid: 1'b1, regWrite: RegWrite_ID, isLoad: MemRead_ID, rd: RD_W'(targetReg_ID)} : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            e      <= '0;
            FWD_EX <= '0;
        end else begin
            e[0]   <= nxt;
            for (int i = 1; i < FWD_STAGES; i++)
                e[i] <= e[i-1];
            FWD_EX <= advance ? sel : '0;
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk) begin
        if (reset)
            stallCount <= '0;
        else if (stall_ID && stallCount != 16'hFFFF)
            stallCount <= stallCount + 16'd1;
    end
`endif
endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb_hazard_fwd_unit: directed and random checks against an instruction-history model
module tb_hazard_fwd_unit;
    localparam int NS = 2, FS = 2, RW = 5, SW = 2;

    logic clk = 1'b0;
    logic reset, instValid_ID, flush_ID, RegWrite_ID, MemRead_ID, stall_ID;
    logic [NS-1:0]    fwdEn_ID;
    logic [NS*RW-1:0] srcReg_ID;
    logic [RW-1:0]    targetReg_ID;
    logic [NS*SW-1:0] FWD_EX;
`ifdef HAZARD_STATS_EN
    logic [15:0]      stall_count;
`endif

    always #5 clk = ~clk;

    hazard_fwd_unit #(.NUM_SRC(NS), .FWD_STAGES(FS), .REG_W(RW)) dut (
        .clk          (clk),
        .reset        (reset),
        .instValid_ID (instValid_ID),
        .flush_ID     (flush_ID),
        .fwdEn_ID     (fwdEn_ID),
        .srcReg_ID    (srcReg_ID),
        .RegWrite_ID  (RegWrite_ID),
        .MemRead_ID   (MemRead_ID),
        .targetReg_ID (targetReg_ID),
        .stall_ID     (stall_ID),
        .FWD_EX       (FWD_EX)
`ifdef HAZARD_STATS_EN
        ,
        .stallCount   (stall_count)
`endif
    );

    typedef struct {bit valid; bit wr; bit ld; int rd;} instr_t;
    instr_t hist[$];
    int   m_cnt = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    logic obs_stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // hist[0] is the instruction now in EX, hist[1] the one in MEM
    function automatic int m_sel(input int r, input bit en);
        if (!en) return 0;
        for (int j = 0; j < FS && j < hist.size(); j++)
            if (hist[j].valid && hist[j].wr && hist[j].rd == r && r != 31) return j + 1;
        return 0;
    endfunction

    task automatic cyc(input bit rs, input bit v, input bit fl, input bit [1:0] en,
                       input int a, input int b, input bit rw, input bit ml, input int rd);
        int sa, sb;
        bit st, adv;
        logic [3:0] ef;
        reset = rs; instValid_ID = v; flush_ID = fl; fwdEn_ID = en;
        srcReg_ID = {5'(b), 5'(a)}; RegWrite_ID = rw; MemRead_ID = ml; targetReg_ID = 5'(rd);
        #1;
        sa = m_sel(a, en[0]);
        sb = m_sel(b, en[1]);
        st = !rs && v && !fl && hist.size() > 0 && hist[0].ld && (sa == 1 || sb == 1);
        obs_stall = stall_ID;
        chk("stall_ID", stall_ID, 32'(st));
        adv = !rs && v && !fl && !st;
        ef = adv ? {2'(sb), 2'(sa)} : 4'd0;
        if (rs) begin
            hist.delete();
            m_cnt = 0;
        end else begin
            if (st && m_cnt < 65535) m_cnt++;
            hist.push_front('{valid: adv, wr: rw, ld: ml, rd: rd});
            if (hist.size() > FS) void'(hist.pop_back());
        end
        @(posedge clk);
        #1;
        chk("FWD_EX", 32'(FWD_EX), 32'(ef));
`ifdef HAZARD_STATS_EN
        chk("stallCount", 32'(stall_count), m_cnt);
`endif
    endtask

    function automatic int pick();
        int t;
        t = $urandom_range(0, 3);
        return t == 3 ? 31 : t + 1;
    endfunction

    initial begin
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 3, 1, 1, 1, 1, 1);
        chk("rst_fwd", 32'(FWD_EX), 0);
        chk("rst_stall", 32'(obs_stall), 0);
        // ADD X1 then consumer Rn=X1, Rm=X3
        cyc(0, 1, 0, 0, 0, 0, 1, 0, 1);
        cyc(0, 1, 0, 3, 1, 3, 0, 0, 0);
        chk("add_x1", 32'(FWD_EX), 32'b0001);
        chk("add_x1_stall", 32'(obs_stall), 0);
        // producer X5 only in MEM
        cyc(0, 1, 0, 0, 0, 0, 1, 0, 5);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 3, 0, 5, 0, 0, 0);
        chk("x5_mem", 32'(FWD_EX), 32'b1000);
        cyc(0, 1, 0, 0, 0, 0, 1, 0, 5);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 1, 0, 5, 0, 0, 0);
        chk("x5_unused", 32'(FWD_EX), 0);
        // nearest of two X7 writers wins
        cyc(0, 1, 0, 0, 0, 0, 1, 0, 7);
        cyc(0, 1, 0, 0, 0, 0, 1, 0, 7);
        cyc(0, 1, 0, 1, 7, 0, 0, 0, 0);
        chk("x7_nearest", 32'(FWD_EX), 32'b0001);
        // load-use: one bubble then MEM/WB forward
        cyc(0, 1, 0, 0, 0, 0, 1, 1, 2);
        cyc(0, 1, 0, 1, 2, 0, 0, 0, 0);
        chk("lu_stall", 32'(obs_stall), 1);
        chk("lu_bubble", 32'(FWD_EX), 0);
        cyc(0, 1, 0, 1, 2, 0, 0, 0, 0);
        chk("lu_release", 32'(obs_stall), 0);
        chk("lu_fwd", 32'(FWD_EX), 32'b0010);
        // X31 never forwarded, never stalls
        cyc(0, 1, 0, 0, 0, 0, 1, 0, 31);
        cyc(0, 1, 0, 1, 31, 0, 0, 0, 0);
        chk("x31_fwd", 32'(FWD_EX), 0);
        cyc(0, 1, 0, 0, 0, 0, 1, 1, 31);
        cyc(0, 1, 0, 1, 31, 0, 0, 0, 0);
        chk("x31_ld", 32'(obs_stall), 0);
        // flush overrides stall
        cyc(0, 1, 0, 0, 0, 0, 1, 1, 4);
        cyc(0, 1, 1, 1, 4, 0, 0, 0, 0);
        chk("flush_stall", 32'(obs_stall), 0);
        chk("flush_fwd", 32'(FWD_EX), 0);
        // reset during a load-use hazard
        cyc(0, 1, 0, 0, 0, 0, 1, 1, 6);
        cyc(1, 1, 0, 1, 6, 0, 0, 0, 0);
        chk("rst_mid_fwd", 32'(FWD_EX), 0);
        cyc(0, 1, 0, 1, 6, 0, 0, 0, 0);
        chk("rst_cleared", 32'(obs_stall), 0);
        chk("rst_cleared_fwd", 32'(FWD_EX), 0);
        // back-to-back loads feeding each other
        cyc(0, 1, 0, 0, 0, 0, 1, 1, 1);
        cyc(0, 1, 0, 1, 1, 0, 1, 1, 2);
        chk("b2b_stall1", 32'(obs_stall), 1);
        cyc(0, 1, 0, 1, 1, 0, 1, 1, 2);
        chk("b2b_go1", 32'(obs_stall), 0);
        chk("b2b_fwd1", 32'(FWD_EX), 32'b0010);
        cyc(0, 1, 0, 3, 2, 2, 0, 0, 0);
        chk("b2b_stall2", 32'(obs_stall), 1);
        cyc(0, 1, 0, 3, 2, 2, 0, 0, 0);
        chk("b2b_fwd2", 32'(FWD_EX), 32'b1010);
        for (int i = 0; i < 400; i++)
            cyc($urandom_range(0, 49) == 0, $urandom_range(0, 5) != 0, $urandom_range(0, 9) == 0,
                2'($urandom_range(0, 3)), pick(), pick(), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), pick());
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
